// File: rtl/spram_ctrl_if.sv
// Request/response bundle for the single-port RAM controller.
// The master issues requests and takes read responses; the slave is the controller.
interface spram_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 14
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/4-1:0]   req_mask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_mask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_mask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/spram_ctrl.sv
// Single-port RAM controller with nibble-masked writes, fixed-latency reads,
// a valid/ready response and optional zero-fill of the array after reset.
module spram_ctrl #(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned ADDR_W         = 14,
    parameter int unsigned READ_LAT       = 1,
    parameter bit          CLEAR_ON_RESET = 1'b0
) (
    input logic        CLK,
    input logic        RESETN,
    spram_ctrl_if.slave bus
);
    localparam int unsigned NIB_W    = DATA_W / 4;
    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam logic [1:0]  LAT_LAST = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {StClear, StIdle, StWait, StResp} state_e;

    state_e              state_q;
    logic [1:0]          wait_cnt_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic                busy_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [DATA_W-1:0]   mem_rd_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                clr_en;
    logic                wr_en;
    logic                rd_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [NIB_W-1:0]    wr_mask;

    always_comb begin
        // req_ready_q is only ever set while in IDLE, so it doubles as the state qualifier
        accept  = RESETN & bus.req_valid & req_ready_q;
        clr_en  = RESETN & (state_q == StClear);
        wr_en   = clr_en | (accept & bus.req_we);
        rd_en   = accept & ~bus.req_we;
        wr_addr = clr_en ? clr_cnt_q : bus.req_addr;
        wr_data = clr_en ? '0 : bus.req_wdata;
        wr_mask = clr_en ? '1 : bus.req_mask;
    end

    // Synchronous-read array with per-nibble write enables, no reset on contents
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < NIB_W; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_addr][4*i +: 4] <= wr_data[4*i +: 4];
                end
            end
        end
        if (rd_en) begin
            mem_rd_q <= mem[bus.req_addr];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q     <= CLEAR_ON_RESET ? StClear : StIdle;
            busy_q      <= CLEAR_ON_RESET;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            clr_cnt_q   <= '0;
            wait_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                StClear: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (rd_en) begin
                        state_q     <= StWait;
                        busy_q      <= 1'b1;
                        req_ready_q <= 1'b0;
                        wait_cnt_q  <= '0;
                    end
                end
                StWait: begin
                    if (wait_cnt_q == LAT_LAST) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= mem_rd_q;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_spram_ctrl.sv
// Bench for spram_ctrl: three lanes (READ_LAT 1..3) share one request stream and are
// scoreboarded per lane; a fourth small instance exercises zero-fill after reset.
module tb_spram_ctrl;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 14;
    localparam int unsigned NL = 3;

    logic CLK    = 1'b0;
    logic RESETN = 1'b0;
    logic cresetn = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Shared request stream for the three latency lanes
    logic          req_valid = 1'b0;
    logic          req_we    = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_mask  = '0;
    logic          rsp_ready = 1'b1;

    typedef struct {
        logic [DW-1:0] data;
        int            acc_cyc;
    } exp_t;

    exp_t exp_q [NL][$];

    logic [NL-1:0] lane_ready;
    logic [NL-1:0] lane_valid;
    logic [NL-1:0] lane_busy;
    logic [DW-1:0] lane_rdata [NL];

    for (genvar k = 0; k < NL; k++) begin : g_lane
        spram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) u_bus ();

        assign u_bus.req_valid = req_valid;
        assign u_bus.req_we    = req_we;
        assign u_bus.req_addr  = req_addr;
        assign u_bus.req_wdata = req_wdata;
        assign u_bus.req_mask  = req_mask;
        assign u_bus.rsp_ready = rsp_ready;

        spram_ctrl #(
            .DATA_W(DW), .ADDR_W(AW), .READ_LAT(k + 1), .CLEAR_ON_RESET(1'b0)
        ) u_dut (
            .CLK   (CLK),
            .RESETN(RESETN),
            .bus   (u_bus)
        );

        assign lane_ready[k] = u_bus.req_ready;
        assign lane_valid[k] = u_bus.rsp_valid;
        assign lane_busy[k]  = u_bus.busy;
        assign lane_rdata[k] = u_bus.rsp_rdata;

        logic          seen = 1'b0;
        logic [DW-1:0] held = '0;
        exp_t          e;

        always @(negedge CLK) begin
            if (u_bus.rsp_valid) begin
                chk($sformatf("lane%0d_req_ready_in_resp", k), {31'b0, u_bus.req_ready}, 0);
                if (!seen) begin
                    if (exp_q[k].size() == 0) begin
                        fail_now($sformatf("lane%0d_unexpected_rsp data=%0h", k,
                                           u_bus.rsp_rdata));
                    end else begin
                        e = exp_q[k].pop_front();
                        chk($sformatf("lane%0d_rdata", k), {16'b0, u_bus.rsp_rdata},
                            {16'b0, e.data});
                        chk($sformatf("lane%0d_latency", k), cyc - e.acc_cyc, k + 1);
                    end
                    seen = 1'b1;
                    held = u_bus.rsp_rdata;
                end else begin
                    chk($sformatf("lane%0d_rdata_hold", k), {16'b0, u_bus.rsp_rdata},
                        {16'b0, held});
                end
                if (rsp_ready) seen = 1'b0;
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Zero-fill instance, small array
    spram_ctrl_if #(.DATA_W(DW), .ADDR_W(4)) cbus ();

    spram_ctrl #(
        .DATA_W(DW), .ADDR_W(4), .READ_LAT(1), .CLEAR_ON_RESET(1'b1)
    ) u_cdut (
        .CLK   (CLK),
        .RESETN(cresetn),
        .bus   (cbus)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    mask;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic wait_ready();
        int n = 0;
        while (!(&lane_ready) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!(&lane_ready)) fail_now("wait_ready_timeout");
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] m, input logic [DW-1:0] x, input bit push);
        wait_ready();
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_mask  = m;
        req_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        if (!we && push) begin
            for (int i = 0; i < NL; i++) exp_q[i].push_back('{data: x, acc_cyc: cyc});
        end
        if (we) chk("write_keeps_ready", {29'b0, lane_ready}, 32'h7);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 || !(&lane_ready))
               && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_pending", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    endtask

    task automatic c_write(input logic [3:0] a, input logic [DW-1:0] d);
        int n = 0;
        while (!cbus.req_ready && n < 64) begin
            @(negedge CLK);
            n++;
        end
        cbus.req_we    = 1'b1;
        cbus.req_addr  = a;
        cbus.req_wdata = d;
        cbus.req_mask  = 4'hF;
        cbus.req_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        cbus.req_valid = 1'b0;
    endtask

    task automatic c_read(input logic [3:0] a, output logic [DW-1:0] d);
        int n = 0;
        while (!cbus.req_ready && n < 64) begin
            @(negedge CLK);
            n++;
        end
        cbus.req_we    = 1'b0;
        cbus.req_addr  = a;
        cbus.req_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        cbus.req_valid = 1'b0;
        n = 0;
        while (!cbus.rsp_valid && n < 16) begin
            @(negedge CLK);
            n++;
        end
        d = cbus.rsp_valid ? cbus.rsp_rdata : 'x;
        @(negedge CLK);
    endtask

    task automatic c_release_count(output int n);
        cresetn = 1'b1;
        n = 0;
        while (cbus.busy && n < 64) begin
            n++;
            @(negedge CLK);
        end
    endtask

    logic [DW-1:0] rd;
    int            nb;

    initial begin
        cbus.req_valid = 1'b0;
        cbus.req_we    = 1'b0;
        cbus.req_addr  = '0;
        cbus.req_wdata = '0;
        cbus.req_mask  = '0;
        cbus.rsp_ready = 1'b1;

        vecs[0]  = '{1'b1, 14'h0007, 16'h0004, 4'hF, 16'h0000};
        vecs[1]  = '{1'b0, 14'h0007, 16'h0000, 4'h0, 16'h0004};
        vecs[2]  = '{1'b1, 14'h0010, 16'hFFFF, 4'hF, 16'h0000};
        vecs[3]  = '{1'b1, 14'h0010, 16'h1234, 4'h5, 16'h0000};
        vecs[4]  = '{1'b0, 14'h0010, 16'h0000, 4'h0, 16'hF2F4};
        vecs[5]  = '{1'b1, 14'h0010, 16'h0000, 4'h0, 16'h0000};
        vecs[6]  = '{1'b0, 14'h0010, 16'h0000, 4'h0, 16'hF2F4};
        vecs[7]  = '{1'b1, 14'h3FFF, 16'hABCD, 4'hF, 16'h0000};
        vecs[8]  = '{1'b0, 14'h3FFF, 16'h0000, 4'h0, 16'hABCD};
        vecs[9]  = '{1'b1, 14'h0000, 16'h1111, 4'hF, 16'h0000};
        vecs[10] = '{1'b1, 14'h0000, 16'hC3C3, 4'h8, 16'h0000};
        vecs[11] = '{1'b0, 14'h0000, 16'h0000, 4'h0, 16'hC111};
        vecs[12] = '{1'b0, 14'h0007, 16'h0000, 4'h0, 16'h0004};

        repeat (3) @(negedge CLK);
        chk("reset_req_ready", {29'b0, lane_ready}, 0);
        chk("reset_rsp_valid", {29'b0, lane_valid}, 0);
        chk("reset_busy", {29'b0, lane_busy}, 0);
        for (int i = 0; i < NL; i++) chk("reset_rsp_rdata", {16'b0, lane_rdata[i]}, 0);
        chk("creset_req_ready", {31'b0, cbus.req_ready}, 0);
        chk("creset_rsp_valid", {31'b0, cbus.rsp_valid}, 0);

        RESETN = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("release_idle_ready", {29'b0, lane_ready}, 32'h7);

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask, vecs[i].exp, 1'b1);
        end
        drain();

        // Response held off by rsp_ready=0, then released
        rsp_ready = 1'b0;
        issue(1'b0, 14'h3FFF, 16'h0, 4'h0, 16'hABCD, 1'b1);
        repeat (8) @(negedge CLK);
        chk("hold_valid_all", {29'b0, lane_valid}, 32'h7);
        chk("hold_ready_low", {29'b0, lane_ready}, 0);
        rsp_ready = 1'b1;
        @(negedge CLK);
        chk("exit_valid_low", {29'b0, lane_valid}, 0);
        chk("exit_ready_high", {29'b0, lane_ready}, 32'h7);
        chk("exit_busy_low", {29'b0, lane_busy}, 0);
        for (int i = 0; i < NL; i++) chk("exit_rdata_kept", {16'b0, lane_rdata[i]}, 16'hABCD);
        drain();

        // Reset one cycle after a read accept discards it
        issue(1'b0, 14'h0007, 16'h0, 4'h0, 16'h0, 1'b0);
        RESETN = 1'b0;
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        repeat (2) @(negedge CLK);
        chk("post_reset_ready", {29'b0, lane_ready}, 32'h7);
        chk("post_reset_busy", {29'b0, lane_busy}, 0);
        repeat (5) @(negedge CLK);
        issue(1'b0, 14'h0007, 16'h0, 4'h0, 16'h0004, 1'b1);
        issue(1'b0, 14'h0010, 16'h0, 4'h0, 16'hF2F4, 1'b1);
        drain();

        // Zero-fill instance
        c_release_count(nb);
        chk("clear_busy_cycles_first", nb, 16);
        chk("clear_done_ready", {31'b0, cbus.req_ready}, 1);
        for (int i = 0; i < 16; i++) c_write(4'(i), 16'hA000 + 16'(i));
        c_read(4'h5, rd);
        chk("preload_readback", {16'b0, rd}, 16'hA005);
        cresetn = 1'b0;
        repeat (2) @(negedge CLK);
        c_release_count(nb);
        chk("clear_busy_cycles", nb, 16);
        for (int i = 0; i < 16; i++) begin
            c_read(4'(i), rd);
            chk($sformatf("clear_addr%0d", i), {16'b0, rd}, 0);
        end

        // Reset in the middle of the fill restarts it from address 0
        c_write(4'h3, 16'h5555);
        c_write(4'hF, 16'h7777);
        cresetn = 1'b0;
        repeat (2) @(negedge CLK);
        cresetn = 1'b1;
        repeat (5) @(negedge CLK);
        cresetn = 1'b0;
        repeat (2) @(negedge CLK);
        c_release_count(nb);
        chk("restart_busy_cycles", nb, 16);
        c_read(4'h3, rd);
        chk("restart_addr3", {16'b0, rd}, 0);
        c_read(4'hF, rd);
        chk("restart_addr15", {16'b0, rd}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
